systolic_result_requant: RTL
============================

Name: systolic_result_requant

Overview:
- Downstream neighbour of systolic_array. Consumes its result row stream (ARRAY_SIZE lanes of ACC_WIDTH accumulators, valid/ready).
- Applies a round-half-up arithmetic right shift, optional ReLU and signed saturation to DATA_WIDTH.
- Buffers the quantized rows in a small output FIFO with valid/ready toward the writeback path.
- Counts rows per job and pulses done once the configured number of rows has been emitted.

Parameters:
- ARRAY_SIZE, 4, number of lanes (columns) per result row
- ACC_WIDTH, 32, input accumulator width per lane, signed
- DATA_WIDTH, 8, output width per lane, signed
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches cfg_* and begins a job (honoured only in IDLE)
- cfg_rows  in  16  rows in this job
- cfg_shift  in  5  right-shift amount, 0..31
- cfg_relu  in  1  1 = clamp negative results to 0
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at job completion
- in_valid  in  1  result row valid (driven from systolic_array result_valid)
- in_data  in  ARRAY_SIZE*ACC_WIDTH  result row; lane j at [j*ACC_WIDTH +: ACC_WIDTH]
- in_ready  out  1  row accepted when in_valid && in_ready
- out_valid  out  1  quantized row available
- out_data  out  ARRAY_SIZE*DATA_WIDTH  lane j at [j*DATA_WIDTH +: DATA_WIDTH]
- out_ready  in  1  row popped when out_valid && out_ready

Behaviour:
- Reset, synchronous and active-high:
  - Outputs go to busy=0, done=0, in_ready=0, out_valid=0, out_data=0.
  - FIFO is emptied, pipeline valids clear, counters are 0, state is IDLE.
  - Reset mid-job discards all in-flight and buffered rows; no done pulse is generated.
- States:
  - IDLE: start captures cfg_rows/cfg_shift/cfg_relu and moves to RUN, or to DONE if cfg_rows==0.
  - RUN: accepts rows. When the accepted count reaches cfg_rows, moves to DRAIN.
  - DRAIN: waits until all accepted rows have been popped from the FIFO, then moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored. cfg_* changes after start have no effect on the current job.
- Input acceptance:
  - in_ready = (state==RUN) && (accepted < cfg_rows) && (fifo_count + rows_in_pipeline < FIFO_DEPTH).
  - This is credit-based, so no row is ever dropped or stalled inside the pipeline.
  - in_ready does not depend combinationally on in_valid.
- Pipeline:
  - Stage 1, registered on the acceptance edge: per lane, sign-extend to ACC_WIDTH+1 bits. If shift>0, add 1<<(shift-1). Then arithmetic shift right by cfg_shift.
  - Stage 2, registered and written to the FIFO: if cfg_relu and the value is negative, the value is 0. Then saturate to [-(2^(DATA_WIDTH-1)), 2^(DATA_WIDTH-1)-1].
  - A row accepted in cycle N is visible as out_valid/out_data in cycle N+2 when the FIFO was empty and out_ready=1. Throughput is 1 row/cycle.
- FIFO:
  - out_data is the head entry and is held stable while out_valid && !out_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Rows are emitted in acceptance order.
- Counters: accepted and emitted are 16-bit and are cleared by start.

Test Plan:
- ARRAY_SIZE=4, shift=0, relu=0, rows=1, in=[3,5,-6,200] -> out=[3,5,-6,127] two cycles after acceptance; done pulses once; busy falls with done.
- shift=2, rows=1, in=[5,6,-5,-6] -> out=[1,2,-1,-1] (rounding check); shift=31, in=[-1,0,1,2^30] -> out=[0,0,0,1].
- relu=1, shift=0, in=[-1,-300,300,0] -> out=[0,0,127,0]; relu=0, same input -> out=[-1,-128,127,0].
- rows=8 with in_valid held high and out_ready=0 -> in_ready falls after exactly 4 rows are accepted, out_valid stays 1, out_data is stable. Then out_ready=1 -> all 8 rows are emitted in order, in_ready reasserts, done pulses the cycle after the 8th pop-completed drain.
- cfg_rows=0 -> done pulses in the cycle after start and no row is accepted. A second start while busy has no effect on counters or cfg.
- Assert rst after 3 of 6 rows -> next cycle out_valid=0, busy=0, in_ready=0, no done pulse. A new job then runs correctly from empty.

Source files
------------

// File: rtl/systolic_result_requant.sv
// rtl/systolic_result_requant.sv - requantizes systolic array result rows (round, relu, saturate) into an output FIFO
// Two-stage pipeline with credit-based input acceptance so no row ever stalls inside the datapath.
module systolic_result_requant #(
   parameter int ARRAY_SIZE = 4,
   parameter int ACC_WIDTH  = 32,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [15:0]                      cfg_rows,
   input  logic [4:0]                       cfg_shift,
   input  logic                             cfg_relu,
   output logic                             busy,
   output logic                             done,
   input  logic                             in_valid,
   input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  in_data,
   output logic                             in_ready,
   output logic                             out_valid,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data,
   input  logic                             out_ready
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = ACC_WIDTH + 1;
   localparam int RW = ARRAY_SIZE * DATA_WIDTH;

   localparam logic signed [EW-1:0] SAT_MAX = {{(EW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [EW-1:0] SAT_MIN = {{(EW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              state;
   logic [15:0]         rows_cfg;
   logic [4:0]          shift_cfg;
   logic                relu_cfg;
   logic [15:0]         accepted;
   logic [15:0]         emitted;

   logic                s1_valid;
   logic signed [EW-1:0] s1_val  [ARRAY_SIZE];
   logic signed [EW-1:0] s1_next [ARRAY_SIZE];
   logic signed [EW-1:0] lane_ext [ARRAY_SIZE];
   logic signed [EW-1:0] lane_sum [ARRAY_SIZE];
   logic signed [EW-1:0] rnd;
   logic [RW-1:0]       s2_row;

   logic [RW-1:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       fifo_count;

   logic                accept;
   logic                push;
   logic                pop;

   // A row in stage 1 already owns a FIFO slot, so it is counted as a credit in use.
   assign in_ready  = (state == S_RUN) && (accepted < rows_cfg) &&
                      ((fifo_count + CW'(s1_valid)) < CW'(FIFO_DEPTH));
   assign accept    = in_valid && in_ready;
   assign push      = s1_valid;
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   always_comb begin
      rnd = '0;
      if (shift_cfg != 5'd0) rnd = EW'(1) << (shift_cfg - 5'd1);
      for (int j = 0; j < ARRAY_SIZE; j++) begin
         lane_ext[j] = $signed({in_data[j*ACC_WIDTH+ACC_WIDTH-1], in_data[j*ACC_WIDTH +: ACC_WIDTH]});
         lane_sum[j] = lane_ext[j] + rnd;
         s1_next[j]  = lane_sum[j] >>> shift_cfg;
      end
   end

   always_comb begin
      s2_row = '0;
      for (int j = 0; j < ARRAY_SIZE; j++) begin
         if (relu_cfg && s1_val[j][EW-1])
            s2_row[j*DATA_WIDTH +: DATA_WIDTH] = '0;
         else if (s1_val[j] > SAT_MAX)
            s2_row[j*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
         else if (s1_val[j] < SAT_MIN)
            s2_row[j*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
         else
            s2_row[j*DATA_WIDTH +: DATA_WIDTH] = s1_val[j][DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int j = 0; j < ARRAY_SIZE; j++) s1_val[j] <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            for (int j = 0; j < ARRAY_SIZE; j++) s1_val[j] <= s1_next[j];
         end
         if (push) begin
            mem[wr_ptr] <= s2_row;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rows_cfg  <= '0;
         shift_cfg <= '0;
         relu_cfg  <= 1'b0;
         accepted  <= '0;
         emitted   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  rows_cfg  <= cfg_rows;
                  shift_cfg <= cfg_shift;
                  relu_cfg  <= cfg_relu;
                  accepted  <= '0;
                  emitted   <= '0;
                  busy      <= 1'b1;
                  if (cfg_rows == 16'd0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (pop) emitted <= emitted + 16'd1;
               if (accept) begin
                  accepted <= accepted + 16'd1;
                  if (accepted + 16'd1 == rows_cfg) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop) emitted <= emitted + 16'd1;
               // Finish on the cycle the last row leaves so done follows the final pop directly.
               if (emitted + 16'(pop) == rows_cfg) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
